// File: rtl/uart_byte_bridge.sv
// rtl/uart_byte_bridge.sv - MMIO register bridge with TX/RX byte FIFOs for the UART byte controller
// Optional TX->RX loopback path is built only when UART_BRIDGE_LOOPBACK_EN is defined.
module uart_byte_bridge #(
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  bus_addr,
  input  logic        bus_wr,
  input  logic        bus_rd,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  output logic        irq,
  output logic [7:0]  uart_send_data,
  output logic        uart_send,
  input  logic        uart_send_busy,
  input  logic [7:0]  uart_rev_data,
  input  logic        uart_rev_data_valid,
  output logic        uart_rev_data_invalid
);

  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} tx_state_e;

  tx_state_e   state_q, state_d;
  logic [TAW:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [RAW:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [7:0]  tx_mem_q [TX_DEPTH];
  logic [7:0]  rx_mem_q [RX_DEPTH];
  logic        send_q, send_d;
  logic [7:0]  send_data_q, send_data_d;
  logic        rev_invalid_q, rev_invalid_d;
  logic        rev_valid_q, rev_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        irq_q, irq_d;
  logic        rx_ovr_q, rx_ovr_d;
  logic        tx_ovf_q, tx_ovf_d;
  logic [2:0]  ctrl_q, ctrl_d;

  logic        sel_data, sel_stat, sel_ctrl;
  logic        tx_empty, tx_full, rx_empty, rx_full, tx_active;
  logic        tx_wr, tx_pop, tx_push_ok, issue, lb_mode, lb_go;
  logic        rx_pop, rx_push_req, rx_push_ok, rx_drop, uart_edge;
  logic [7:0]  tx_head, rx_head, rx_push_byte, rx_count8, ctrl_wbit2_byte;
  logic [RAW:0] rx_cnt;
  logic [31:0] status_word;
  logic        unused_ok;

  assign unused_ok = ^{bus_addr[1:0], bus_wdata[31:8], bus_wdata[2], ctrl_wbit2_byte};

`ifdef UART_BRIDGE_LOOPBACK_EN
  assign lb_mode         = ctrl_q[2];
  assign ctrl_wbit2_byte = {7'b0, bus_wdata[2]};
`else
  assign lb_mode         = 1'b0;
  assign ctrl_wbit2_byte = 8'h00;
`endif

  always_comb begin
    sel_data  = (bus_addr[3:2] == 2'd0);
    sel_stat  = (bus_addr[3:2] == 2'd1);
    sel_ctrl  = (bus_addr[3:2] == 2'd2);
    tx_empty  = (tx_wp_q == tx_rp_q);
    tx_full   = (tx_wp_q[TAW] != tx_rp_q[TAW]) && (tx_wp_q[TAW-1:0] == tx_rp_q[TAW-1:0]);
    rx_empty  = (rx_wp_q == rx_rp_q);
    rx_full   = (rx_wp_q[RAW] != rx_rp_q[RAW]) && (rx_wp_q[RAW-1:0] == rx_rp_q[RAW-1:0]);
    tx_head   = tx_mem_q[tx_rp_q[TAW-1:0]];
    rx_head   = rx_mem_q[rx_rp_q[RAW-1:0]];
    rx_cnt    = rx_wp_q - rx_rp_q;
    rx_count8 = 8'(rx_cnt);
    tx_active = (state_q != IDLE) || !tx_empty;
    uart_edge = uart_rev_data_valid && !rev_valid_q;

    // Never issue while the controller still reports busy (e.g. a byte left over from before reset)
    issue  = (state_q == IDLE) && !tx_empty && !lb_mode && !uart_send_busy;
    lb_go  = (state_q == IDLE) && !tx_empty && lb_mode && !uart_edge;
    tx_pop = issue || lb_go;

    tx_wr      = bus_wr && sel_data;
    tx_push_ok = tx_wr && (!tx_full || tx_pop);

    rx_pop       = bus_rd && sel_data && !rx_empty;
    rx_push_req  = uart_edge || lb_go;
    rx_push_ok   = rx_push_req && (!rx_full || rx_pop);
    rx_drop      = rx_push_req && rx_full && !rx_pop;
    rx_push_byte = uart_edge ? uart_rev_data : tx_head;

    tx_wp_d = tx_wp_q + {{TAW{1'b0}}, tx_push_ok};
    tx_rp_d = tx_rp_q + {{TAW{1'b0}}, tx_pop};
    rx_wp_d = rx_wp_q + {{RAW{1'b0}}, rx_push_ok};
    rx_rp_d = rx_rp_q + {{RAW{1'b0}}, rx_pop};

    state_d = state_q;
    case (state_q)
      IDLE:    if (issue) state_d = WAIT_HI;
      WAIT_HI: if (uart_send_busy) state_d = WAIT_LO;
      WAIT_LO: if (!uart_send_busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    send_d        = issue;
    send_data_d   = issue ? tx_head : send_data_q;
    rev_invalid_d = uart_edge;
    rev_valid_d   = uart_rev_data_valid;

    rx_ovr_d = rx_ovr_q;
    tx_ovf_d = tx_ovf_q;
    if (bus_wr && sel_stat && bus_wdata[4]) rx_ovr_d = 1'b0;
    if (bus_wr && sel_stat && bus_wdata[5]) tx_ovf_d = 1'b0;
    if (rx_drop) rx_ovr_d = 1'b1;
    if (tx_wr && tx_full && !tx_pop) tx_ovf_d = 1'b1;

    ctrl_d = ctrl_q;
    if (bus_wr && sel_ctrl) ctrl_d = {ctrl_wbit2_byte[0], bus_wdata[1:0]};

    status_word = {16'h0, rx_count8, 1'b0, tx_active, tx_ovf_q, rx_ovr_q,
                   rx_full, rx_empty, tx_empty, tx_full};
    rdata_d = rdata_q;
    if (bus_rd) begin
      case (bus_addr[3:2])
        2'd0:    rdata_d = {24'h0, rx_empty ? 8'h00 : rx_head};
        2'd1:    rdata_d = status_word;
        2'd2:    rdata_d = {29'h0, ctrl_q};
        default: rdata_d = 32'h0;
      endcase
    end

    irq_d = (ctrl_q[0] && !rx_empty) || (ctrl_q[1] && tx_empty && (state_q == IDLE)) || rx_ovr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      tx_wp_q       <= '0;
      tx_rp_q       <= '0;
      rx_wp_q       <= '0;
      rx_rp_q       <= '0;
      send_q        <= 1'b0;
      send_data_q   <= 8'h00;
      rev_invalid_q <= 1'b0;
      rev_valid_q   <= 1'b0;
      rdata_q       <= 32'h0;
      irq_q         <= 1'b0;
      rx_ovr_q      <= 1'b0;
      tx_ovf_q      <= 1'b0;
      ctrl_q        <= 3'b000;
    end else begin
      state_q       <= state_d;
      tx_wp_q       <= tx_wp_d;
      tx_rp_q       <= tx_rp_d;
      rx_wp_q       <= rx_wp_d;
      rx_rp_q       <= rx_rp_d;
      send_q        <= send_d;
      send_data_q   <= send_data_d;
      rev_invalid_q <= rev_invalid_d;
      rev_valid_q   <= rev_valid_d;
      rdata_q       <= rdata_d;
      irq_q         <= irq_d;
      rx_ovr_q      <= rx_ovr_d;
      tx_ovf_q      <= tx_ovf_d;
      ctrl_q        <= ctrl_d;
    end
  end

  // Storage is not reset; pointers alone define contents
  always_ff @(posedge clk) begin
    if (tx_push_ok) tx_mem_q[tx_wp_q[TAW-1:0]] <= bus_wdata[7:0];
    if (rx_push_ok) rx_mem_q[rx_wp_q[RAW-1:0]] <= rx_push_byte;
  end

  assign bus_rdata             = rdata_q;
  assign irq                   = irq_q;
  assign uart_send             = send_q;
  assign uart_send_data        = send_data_q;
  assign uart_rev_data_invalid = rev_invalid_q;

endmodule

// File: tb/tb_uart_byte_bridge.sv
// tb/tb_uart_byte_bridge.sv - self-checking bench for uart_byte_bridge
// Register vectors from a table plus directed TX/RX/overflow/reset sequences.
module tb_uart_byte_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  bus_addr = 4'h0;
  logic        bus_wr = 1'b0;
  logic        bus_rd = 1'b0;
  logic [31:0] bus_wdata = 32'h0;
  logic [31:0] bus_rdata;
  logic        irq;
  logic [7:0]  uart_send_data;
  logic        uart_send;
  logic        uart_send_busy;
  logic [7:0]  uart_rev_data = 8'h00;
  logic        uart_rev_data_valid = 1'b0;
  logic        uart_rev_data_invalid;

  uart_byte_bridge #(.TX_DEPTH(16), .RX_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_wr(bus_wr), .bus_rd(bus_rd),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .irq(irq),
    .uart_send_data(uart_send_data), .uart_send(uart_send), .uart_send_busy(uart_send_busy),
    .uart_rev_data(uart_rev_data), .uart_rev_data_valid(uart_rev_data_valid),
    .uart_rev_data_invalid(uart_rev_data_invalid)
  );

  always #5 clk = ~clk;

`ifdef UART_BRIDGE_LOOPBACK_EN
  localparam logic [31:0] CTRL_RB = 32'h7;
`else
  localparam logic [31:0] CTRL_RB = 32'h3;
`endif

  // Controller model: busy for 10 cycles after each send pulse
  logic       hold_busy = 1'b0;
  int         busy_cnt = 0;
  int         n_sent = 0;
  int         n_busy_viol = 0;
  int         n_falls = 0;
  int         n_inv = 0;
  logic [7:0] sent [64];

  assign uart_send_busy = hold_busy || (busy_cnt != 0);

  always @(posedge clk) begin
    if (uart_send) begin
      if (uart_send_busy) n_busy_viol <= n_busy_viol + 1;
      sent[n_sent[5:0]] <= uart_send_data;
      n_sent <= n_sent + 1;
      busy_cnt <= 10;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) n_falls <= n_falls + 1;
    end
    if (uart_rev_data_invalid) n_inv <= n_inv + 1;
  end

  int n_total = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    bus_addr = a; bus_wdata = d; bus_wr = 1'b1;
    @(posedge clk); #1;
    bus_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    bus_addr = a; bus_rd = 1'b1;
    @(posedge clk); #1;
    bus_rd = 1'b0;
    d = bus_rdata;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Hold valid until acknowledged, plus one extra cycle to show a held level is not re-pushed
  task automatic rx_byte(input logic [7:0] b, output logic ok);
    uart_rev_data = b; uart_rev_data_valid = 1'b1; ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(posedge clk); #1;
      if (uart_rev_data_invalid) ok = 1'b1;
    end
    @(posedge clk); #1;
    uart_rev_data_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [31:0] r;
    logic        ok;
    logic        all_ok;
    int          base, falls0, inv0, cnt;

    vecs[0]  = '{1'b0, 4'h4, 32'h0,        32'h06,  1'b0};
    vecs[1]  = '{1'b0, 4'h8, 32'h0,        32'h0,   1'b0};
    vecs[2]  = '{1'b0, 4'h0, 32'h0,        32'h0,   1'b0};
    vecs[3]  = '{1'b1, 4'h8, 32'hFF,       32'h0,   1'b0};
    vecs[4]  = '{1'b0, 4'h8, 32'h0,        CTRL_RB, 1'b1};
    vecs[5]  = '{1'b1, 4'hC, 32'hFFFFFFFF, 32'h0,   1'b1};
    vecs[6]  = '{1'b0, 4'hC, 32'h0,        32'h0,   1'b1};
    vecs[7]  = '{1'b0, 4'h8, 32'h0,        CTRL_RB, 1'b1};
    vecs[8]  = '{1'b1, 4'h8, 32'h0,        32'h0,   1'b1};
    vecs[9]  = '{1'b0, 4'h8, 32'h0,        32'h0,   1'b0};
    vecs[10] = '{1'b1, 4'h4, 32'h30,       32'h0,   1'b0};
    vecs[11] = '{1'b0, 4'h4, 32'h0,        32'h06,  1'b0};

    // Reset state
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdata", bus_rdata, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_send", {31'h0, uart_send}, 32'h0);
    check("rst_send_data", {24'h0, uart_send_data}, 32'h0);
    check("rst_invalid", {31'h0, uart_rev_data_invalid}, 32'h0);
    rst = 1'b1;
    idle(1);

    // Register table
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].data);
      else begin
        bus_read(vecs[i].addr, r);
        check($sformatf("vec%0d_rdata", i), r, vecs[i].exp_rd);
      end
      check($sformatf("vec%0d_irq", i), {31'h0, irq}, {31'h0, vecs[i].exp_irq});
    end

    // TX: two bytes, busy 10 cycles each
    base = n_sent; falls0 = n_falls;
    bus_write(4'h0, 32'h41);
    bus_write(4'h0, 32'h42);
    bus_read(4'h4, r);
    check("tx_active_early", {31'h0, r[6]}, 32'h1);
    cnt = 0;
    while (r[6] && cnt < 200) begin
      bus_read(4'h4, r);
      cnt++;
    end
    check("tx_active_fall_timeout", {31'h0, r[6]}, 32'h0);
    check("tx_active_after_2nd_fall", n_falls - falls0, 32'd2);
    idle(5);
    check("tx_two_sends", n_sent - base, 32'd2);
    check("tx_byte0", {24'h0, sent[base[5:0]]}, 32'h41);
    check("tx_byte1", {24'h0, sent[6'(base + 1)]}, 32'h42);
    check("tx_no_send_while_busy", n_busy_viol, 32'd0);

    // RX: single byte
    inv0 = n_inv;
    rx_byte(8'h5A, ok);
    idle(2);
    check("rx_ack_seen", {31'h0, ok}, 32'h1);
    check("rx_one_invalid", n_inv - inv0, 32'd1);
    bus_read(4'h4, r);
    check("rx_status_count1", r, 32'h0102);
    bus_read(4'h0, r);
    check("rx_data_5a", r, 32'h5A);
    bus_read(4'h4, r);
    check("rx_empty_after_pop", {31'h0, r[2]}, 32'h1);
    bus_read(4'h0, r);
    check("rx_empty_read_zero", r, 32'h0);

    // RX overflow: 17 bytes into a 16-deep FIFO
    inv0 = n_inv; all_ok = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      rx_byte(8'(i), ok);
      all_ok = all_ok & ok;
    end
    idle(1);
    check("ovr_all_acked", {31'h0, all_ok}, 32'h1);
    check("ovr_invalid_count", n_inv - inv0, 32'd17);
    bus_read(4'h4, r);
    check("ovr_status", r, 32'h101A);
    check("ovr_irq", {31'h0, irq}, 32'h1);
    for (int i = 1; i <= 16; i++) begin
      bus_read(4'h0, r);
      check($sformatf("ovr_data%0d", i), r, 32'(i));
    end
    bus_write(4'h4, 32'h10);
    bus_read(4'h4, r);
    check("ovr_cleared_status", r, 32'h06);
    check("ovr_cleared_irq", {31'h0, irq}, 32'h0);

    // TX overflow while controller stays busy, then drain
    hold_busy = 1'b1;
    base = n_sent;
    for (int i = 0; i < 17; i++) bus_write(4'h0, 32'hA0 + 32'(i));
    bus_read(4'h4, r);
    check("txovf_status", r, 32'h65);
    check("txovf_none_sent", n_sent - base, 32'd0);
    hold_busy = 1'b0;
    cnt = 0;
    while (n_sent - base < 16 && cnt < 600) begin idle(1); cnt++; end
    check("txovf_drain_count", n_sent - base, 32'd16);
    all_ok = 1'b1;
    for (int i = 0; i < 16; i++)
      if (sent[6'(base + i)] !== 8'(8'hA0 + i)) all_ok = 1'b0;
    check("txovf_drain_order", {31'h0, all_ok}, 32'h1);
    bus_write(4'h4, 32'h20);
    r = 32'hFFFF;
    cnt = 0;
    while (r[6] && cnt < 100) begin bus_read(4'h4, r); cnt++; end
    check("txovf_idle_status", r, 32'h06);
    check("txovf_no_send_while_busy", n_busy_viol, 32'd0);

    // Reset mid-drain with 5 bytes queued
    base = n_sent;
    for (int i = 0; i < 6; i++) bus_write(4'h0, 32'hC0 + 32'(i));
    cnt = 0;
    while (n_sent == base && cnt < 50) begin idle(1); cnt++; end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    idle(40);
    check("rst_mid_sends", n_sent - base, 32'd1);
    check("rst_mid_send_low", {31'h0, uart_send}, 32'h0);
    bus_read(4'h4, r);
    check("rst_mid_status", r, 32'h06);

`ifdef UART_BRIDGE_LOOPBACK_EN
    base = n_sent;
    bus_write(4'h8, 32'h4);
    bus_write(4'h0, 32'h11);
    bus_write(4'h0, 32'h22);
    bus_write(4'h0, 32'h33);
    idle(5);
    bus_read(4'h0, r);
    check("lb_data0", r, 32'h11);
    bus_read(4'h0, r);
    check("lb_data1", r, 32'h22);
    bus_read(4'h0, r);
    check("lb_data2", r, 32'h33);
    check("lb_no_send", n_sent - base, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/uart_byte_bridge.md
Name: uart_byte_bridge

Overview:
- Host-side peer of the UART byte controller: drives its send/send_data/send_busy handshake and consumes its rev_data/rev_data_valid/rev_data_invalid handshake.
- Buffers both directions in FIFOs and exposes them through a small register interface to the core's MMIO bus.
- Sits between the MMIO decoder and the UART controller instance.

Parameters:
- TX_DEPTH, 16: TX FIFO entries; power of 2, ≥2.
- RX_DEPTH, 16: RX FIFO entries; power of 2, ≥2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- bus_addr  in  4  register byte offset; bits[1:0] ignored
- bus_wr  in  1  write strobe, one cycle per access
- bus_rd  in  1  read strobe, one cycle per access
- bus_wdata  in  32  write data
- bus_rdata  out  32  read data, registered
- irq  out  1  level interrupt
- uart_send_data  out  8  byte to transmit
- uart_send  out  1  one-cycle transmit request
- uart_send_busy  in  1  controller transmitting
- uart_rev_data  in  8  received byte
- uart_rev_data_valid  in  1  received byte valid
- uart_rev_data_invalid  out  1  one-cycle acknowledge/clear of rev_data_valid

Behaviour:
- One clock; reset is synchronous and active-low. rst=0 at a clk edge resets the block.
- Reset values:
  - bus_rdata=0, irq=0, uart_send=0, uart_send_data=0, uart_rev_data_invalid=0.
  - Both FIFOs empty, sticky flags 0, CTRL=0, TX FSM in IDLE, rev_valid edge register=0.
- Register map:
  - 0x0 DATA
    - Write: push bus_wdata[7:0] to the TX FIFO. If full, drop the byte and set tx_ovf.
    - Read: pop the RX FIFO and return {24'b0, byte}. If empty, return 0 with no pop.
  - 0x4 STATUS (read)
    - bit0 tx_full, bit1 tx_empty, bit2 rx_empty, bit3 rx_full.
    - bit4 rx_ovr (sticky), bit5 tx_ovf (sticky).
    - bit6 tx_active: FSM≠IDLE or TX FIFO non-empty.
    - bits[15:8] rx_count, zero-extended.
    - Write: 1 in bit4 or bit5 clears that sticky flag.
  - 0x8 CTRL (R/W)
    - bit0 rx_irq_en, bit1 tx_irq_en, bit2 loopback (see Optional Feature).
  - Other offsets: reads return 0, writes are ignored.
- Read latency: bus_rdata is valid the cycle after bus_rd and holds until the next read.
- Simultaneous bus_rd and bus_wr: both take effect.
- irq = (rx_irq_en & ~rx_empty) | (tx_irq_en & tx_empty & FSM==IDLE) | rx_ovr. irq is registered.
- TX FSM:
  - IDLE: if TX FIFO non-empty, load uart_send_data from the head, pop, assert uart_send for one cycle, go to WAIT_HI.
  - WAIT_HI: go to WAIT_LO when uart_send_busy=1.
  - WAIT_LO: go to IDLE when uart_send_busy=0.
  - Minimum spacing between uart_send pulses is 3 cycles plus the controller's busy time. uart_send is never asserted while uart_send_busy=1.
  - uart_send_data holds its value until the next issue.
- RX path:
  - Register uart_rev_data_valid. On a rising edge (valid=1, previous=0), push uart_rev_data and pulse uart_rev_data_invalid for one cycle.
  - If the RX FIFO is full, drop the byte, set rx_ovr, and still pulse invalid.
  - Valid held high with no new edge never causes a second push.
- Same-cycle push and pop on one FIFO: both occur and the count is unchanged.
  - Pop of an empty FIFO with a simultaneous push: return 0 and keep the pushed byte.
  - Push to a full FIFO with a simultaneous pop: accepted.
- FIFO pointers are log2(depth)+1 bits and wrap naturally. Full = MSBs differ and low bits equal.
- Reset mid-transfer: FIFOs flush and the FSM returns to IDLE. A byte already handed to the controller completes on the line, and the bridge ignores the resulting busy fall.

Optional Feature:
- Macro: UART_BRIDGE_LOOPBACK_EN.
- Defined:
  - CTRL bit2 is writable.
  - When set, IDLE pops the TX head and pushes it directly into the RX FIFO, with the same overflow rules, instead of issuing uart_send.
  - FSM stays in IDLE for this transfer, one byte per cycle.
  - UART RX edges are still accepted. If a loopback push and a UART push fall in the same cycle, the UART byte takes priority and the loopback pop stalls.
- Undefined: CTRL bit2 reads 0, writes are ignored, and no loopback logic is built.

Test Plan:
- Write 0x41 then 0x42 to DATA, model busy high for 10 cycles after each send:
  - exactly two uart_send pulses with data 0x41 then 0x42, never while busy.
  - STATUS bit6 falls after the second busy fall.
- Drive rev_data 0x5A with valid held until invalid:
  - one invalid pulse, rx_count=1.
  - DATA read returns 0x5A, then STATUS bit2=1, and a second DATA read returns 0.
- Fill RX with 16 bytes, send a 17th:
  - rx_ovr=1 and irq=1, FIFO contents are bytes 1..16 in order.
  - Write 0x10 to STATUS clears rx_ovr.
- Write 17 bytes to DATA while busy stays high:
  - 16 bytes are buffered and tx_ovf=1.
  - Release busy: bytes drain in order.
- Assert rst=0 for 1 cycle mid-drain with 5 bytes queued:
  - FIFO empty, uart_send stays 0 afterwards, STATUS reads 0x06.
- With UART_BRIDGE_LOOPBACK_EN defined, CTRL=0x4, write 0x11, 0x22, 0x33:
  - no uart_send pulse.
  - DATA reads return 0x11, 0x22, 0x33.
